// File: rtl/prewish_debounce_ctrl.sv
// Shared-prescaler, round-robin debouncer for 8 buttons with STB/DAT readback.
// Optional sticky press reporting: define PREWISH_DB_PRESS_LATCH_EN.
module prewish_debounce_ctrl #(
  parameter int TICK_PERIOD  = 12000,
  parameter int TICK_BITS    = 14,
  parameter int STABLE_TICKS = 8,
  parameter int CNT_BITS     = 4
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] i_buttons,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_changed,
  output logic       o_alive
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACK} req_t;

  logic [7:0]          r_meta;
  logic [7:0]          r_sync;
  logic [TICK_BITS-1:0] r_pre;
  scan_t               r_scan;
  scan_t               w_scan_nx;
  req_t                r_req;
  req_t                w_req_nx;
  logic [2:0]          r_idx;
  logic                r_any_flip;
  logic                r_any_rise;
  logic [7:0]          r_state;
  logic [CNT_BITS-1:0] r_cnt [8];
  logic                r_changed;
  logic                r_alive;
  logic                r_stb;
  logic [7:0]          r_dat;

  logic                w_tick;
  logic                w_cur;
  logic                w_st;
  logic [CNT_BITS-1:0] w_inc;
  logic                w_hit;
  logic                w_rise;
  logic                w_latch;

  assign w_tick  = (r_pre == '0);
  assign w_cur   = r_sync[r_idx];
  assign w_st    = r_state[r_idx];
  assign w_inc   = r_cnt[r_idx] + CNT_BITS'(1);
  assign w_hit   = (w_inc == CNT_BITS'(STABLE_TICKS));
  assign w_rise  = (r_scan == S_SCAN) && (w_cur != w_st) && w_hit && w_cur;
  assign w_latch = (r_req == R_IDLE) && STB_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_meta <= '0;
      r_sync <= '0;
      r_pre  <= '0;
    end else begin
      r_meta <= i_buttons;
      r_sync <= r_meta;
      r_pre  <= w_tick ? TICK_BITS'(TICK_PERIOD - 1) : r_pre - TICK_BITS'(1);
    end
  end

  always_comb begin
    w_scan_nx = r_scan;
    unique case (r_scan)
      S_IDLE:  if (w_tick) w_scan_nx = S_SCAN;
      S_SCAN:  if (r_idx == 3'd7) w_scan_nx = S_DONE;
      S_DONE:  w_scan_nx = S_IDLE;
      default: w_scan_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_scan     <= S_IDLE;
      r_idx      <= '0;
      r_any_flip <= 1'b0;
      r_any_rise <= 1'b0;
      r_state    <= '0;
      r_changed  <= 1'b0;
      r_alive    <= 1'b0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_scan    <= w_scan_nx;
      r_changed <= 1'b0;
      unique case (r_scan)
        S_IDLE: begin
          if (w_tick) begin
            r_idx      <= '0;
            r_any_flip <= 1'b0;
            r_any_rise <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_cur == w_st) begin
            r_cnt[r_idx] <= '0;
          end else if (w_hit) begin
            r_state[r_idx] <= w_cur;
            r_cnt[r_idx]   <= '0;
            r_any_flip     <= 1'b1;
            if (w_cur) r_any_rise <= 1'b1;
          end else begin
            r_cnt[r_idx] <= w_inc;
          end
          r_idx <= r_idx + 3'd1;
        end
        S_DONE: begin
          r_changed <= r_any_flip;
          // One alive toggle per scan, however many channels rose in it
          r_alive   <= r_alive ^ r_any_rise;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_req_nx = r_req;
    unique case (r_req)
      R_IDLE:  if (STB_I) w_req_nx = R_WAIT;
      R_WAIT:  if (!STB_I) w_req_nx = R_ACK;
      R_ACK:   w_req_nx = R_IDLE;
      default: w_req_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_req <= R_IDLE;
      r_stb <= 1'b0;
    end else begin
      r_req <= w_req_nx;
      r_stb <= (r_req == R_WAIT) && !STB_I;
    end
  end

`ifdef PREWISH_DB_PRESS_LATCH_EN
  logic [7:0] r_press;
  logic [7:0] w_set;
  logic [7:0] w_clr;

  assign w_set = w_rise ? (8'd1 << r_idx) : 8'd0;
  assign w_clr = w_latch ? DAT_I : 8'd0;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_press <= '0;
      r_dat   <= '0;
    end else begin
      r_press <= (r_press & ~w_clr) | w_set;
      if (w_latch) r_dat <= r_press & DAT_I;
    end
  end
`else
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_dat <= '0;
    else if (w_latch) r_dat <= r_state & DAT_I;
  end
`endif

  assign STB_O     = r_stb;
  assign DAT_O     = r_dat;
  assign o_changed = r_changed;
  assign o_alive   = ~r_alive;

endmodule

// File: tb/tb_prewish_debounce_ctrl.sv
// Directed vector bench for prewish_debounce_ctrl (TICK_PERIOD=10, STABLE_TICKS=3).
// Expected columns cover both builds of PREWISH_DB_PRESS_LATCH_EN.
module tb_prewish_debounce_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       stb_i = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic       stb_o;
  logic [7:0] dat_o;
  logic       changed;
  logic       alive;

  int n_vec = 0;
  int n_err = 0;
  int chg_cnt = 0;
  int cyc = 0;

  prewish_debounce_ctrl #(
    .TICK_PERIOD(10),
    .TICK_BITS(14),
    .STABLE_TICKS(3),
    .CNT_BITS(4)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .i_buttons(buttons),
    .STB_I(stb_i),
    .DAT_I(dat_i),
    .STB_O(stb_o),
    .DAT_O(dat_o),
    .o_changed(changed),
    .o_alive(alive)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) if (changed === 1'b1) chg_cnt++;

  typedef struct {
    logic [7:0] btn;
    logic [7:0] mask;
    logic [7:0] exp_lvl;
    logic [7:0] exp_prs;
    logic       exp_alive;
    int         exp_chg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick(input logic [7:0] lvl, input logic [7:0] prs);
`ifdef PREWISH_DB_PRESS_LATCH_EN
    return prs;
`else
    return lvl;
`endif
  endfunction

  // Ticks land on edges 0,10,20.. after reset; change pads two edges before one
  task automatic align();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (cyc % 10 == 9) break;
    end
  endtask

  task automatic req(input logic [7:0] mask, output logic [7:0] dat);
    stb_i = 1'b1;
    dat_i = mask;
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("stb_pulse", {7'd0, stb_o}, 8'd1);
    dat = dat_o;
    @(posedge clk);
    #1;
    chk("stb_end", {7'd0, stb_o}, 8'd0);
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [7:0] d;
    align();
    buttons = v.btn;
    chg_cnt = 0;
    repeat (25) @(posedge clk);
    #1;
    chk({name, "_early_chg"}, 8'(chg_cnt), 8'd0);
    repeat (15) @(posedge clk);
    #1;
    chk({name, "_chg"}, 8'(chg_cnt), 8'(v.exp_chg));
    req(v.mask, d);
    chk({name, "_dat"}, d, pick(v.exp_lvl, v.exp_prs));
    chk({name, "_alive"}, {7'd0, alive}, {7'd0, v.exp_alive});
  endtask

  initial begin
    logic [7:0] d;
    vec_t h;

    vecs[0] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 0};
    vecs[1] = '{8'h05, 8'hFF, 8'h05, 8'h05, 1'b0, 1};
    vecs[2] = '{8'hFF, 8'h0F, 8'h0F, 8'h0A, 1'b1, 1};
    vecs[3] = '{8'hFF, 8'hF0, 8'hF0, 8'hF0, 1'b1, 0};
    vecs[4] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1};
    vecs[5] = '{8'hA5, 8'h3C, 8'h24, 8'h24, 1'b0, 1};
    vecs[6] = '{8'h5A, 8'hFF, 8'h5A, 8'hDB, 1'b1, 1};
    vecs[7] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1};

    #2;
    chk("rst_stb", {7'd0, stb_o}, 8'd0);
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_alive", {7'd0, alive}, 8'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Glitch on bit 3 spanning at most two samples
    align();
    buttons = 8'h08;
    chg_cnt = 0;
    repeat (12) @(posedge clk);
    #1;
    buttons = 8'h00;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_chg", 8'(chg_cnt), 8'd0);
    req(8'hFF, d);
    chk("glitch_dat", d, 8'h00);

    // STB_I held high: no response until it drops
    align();
    buttons = 8'hFF;
    chg_cnt = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("hold_chg", 8'(chg_cnt), 8'd1);
    stb_i = 1'b1;
    dat_i = 8'h0F;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold_stb_low", {7'd0, stb_o}, 8'd0);
    end
    stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_stb_pulse", {7'd0, stb_o}, 8'd1);
    chk("hold_dat", dat_o, 8'h0F);
    @(posedge clk);
    #1;
    chk("hold_stb_end", {7'd0, stb_o}, 8'd0);
    chk("hold_alive", {7'd0, alive}, 8'd0);

    // Press then release bit 1, sticky report then cleared
    h = '{8'h00, 8'hFF, 8'h00, 8'hF0, 1'b0, 1};
    apply(h, "rel_all");
    h = '{8'h02, 8'h00, 8'h00, 8'h00, 1'b1, 1};
    apply(h, "press1");
    h = '{8'h00, 8'hFF, 8'h00, 8'h02, 1'b1, 1};
    apply(h, "release1");
    req(8'hFF, d);
    chk("press_again", d, 8'h00);

    // Asynchronous reset mid-scan
    h = '{8'h05, 8'hFF, 8'h05, 8'h05, 1'b0, 1};
    apply(h, "pre_rst");
    align();
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_dat", dat_o, 8'h00);
    chk("mid_rst_stb", {7'd0, stb_o}, 8'd0);
    chk("mid_rst_chg", {7'd0, changed}, 8'd0);
    chk("mid_rst_alive", {7'd0, alive}, 8'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    req(8'hFF, d);
    chk("post_rst_dat", d, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
